// File: rtl/clip_player_if.sv
// Audio_Controller FIFO write port carried by clip_player.
// The player drives the master side; the FIFO owns audio_out_allowed.
interface clip_player_if;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;

    modport master (
        input  audio_out_allowed,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        output audio_out_allowed,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );
endinterface

// File: rtl/clip_player.sv
// Plays a region of a synchronous sample ROM into the audio FIFO,
// one-shot or looping, with per-sample repeat and attenuation.
module clip_player #(
    parameter int ADDR_W   = 16,
    parameter int SAMPLE_W = 16,
    parameter int REPEAT   = 1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_mode,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [2:0]          atten,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    clip_player_if.master       audio,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] PLAY  = 2'd3;

    logic [1:0]                state;
    logic [ADDR_W-1:0]         start_reg;
    logic [ADDR_W-1:0]         len_reg;
    logic [ADDR_W-1:0]         cur_addr;
    logic [ADDR_W-1:0]         remaining;
    logic [SAMPLE_W-1:0]       sample_reg;
    logic [7:0]                rep_cnt;
    logic                      wr;
    logic                      rep_more;
    logic                      last;
    logic signed [SAMPLE_W-1:0] shifted;
    logic [31:0]               word;

    // stop wins over a pending write in the same cycle
    assign wr       = (state == PLAY) && audio.audio_out_allowed && !stop;
    assign rep_more = rep_cnt < 8'(REPEAT - 1);
    assign last     = remaining == ADDR_W'(1);
    assign shifted  = $signed(sample_reg) >>> atten;

    always_comb begin
        word = '0;
        word[31 -: SAMPLE_W] = shifted;
    end

    assign audio.write_audio_out         = wr;
    assign audio.left_channel_audio_out  = (state == PLAY) ? word : '0;
    assign audio.right_channel_audio_out = (state == PLAY) ? word : '0;
    assign busy = state != IDLE;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            start_reg  <= '0;
            len_reg    <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            rom_addr   <= '0;
            sample_reg <= '0;
            rep_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && length != '0) begin
                            start_reg <= start_addr;
                            len_reg   <= length;
                            cur_addr  <= start_addr;
                            remaining <= length;
                            rep_cnt   <= '0;
                            state     <= FETCH;
                        end
                    end
                    FETCH: begin
                        rom_addr <= cur_addr;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        sample_reg <= rom_q;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (wr) begin
                            if (rep_more) begin
                                rep_cnt <= rep_cnt + 8'd1;
                            end else begin
                                rep_cnt <= '0;
                                if (!last) begin
                                    cur_addr  <= cur_addr + ADDR_W'(1);
                                    remaining <= remaining - ADDR_W'(1);
                                    state     <= FETCH;
                                end else if (loop_mode) begin
                                    cur_addr  <= start_reg;
                                    remaining <= len_reg;
                                    state     <= FETCH;
                                end else begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/clip_player.md
Name: clip_player

Overview:
- Parametrised successor to the fixed single-clip ROM looper.
- Plays a selectable region of an external synchronous sample ROM into the Audio_Controller output FIFO, either one-shot or looping.
- Supports per-sample repeat for rate matching, attenuation, and start/stop control.
- Sits between the note/clip ROMs and Audio_Controller in the trumpet practice datapath.

Parameters:
- ADDR_W, 16, ROM address width; addresses wrap modulo 2^ADDR_W.
- SAMPLE_W, 16, ROM sample width, two's complement; legal range 1..32.
- REPEAT, 1, number of FIFO writes per ROM sample; legal range 1..255.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- stop  in  1  single-cycle abort; honoured in any state.
- loop_mode  in  1  1 = loop at end of region, 0 = one-shot; sampled at end of region.
- start_addr  in  ADDR_W  first ROM address of the region; captured on an accepted start.
- length  in  ADDR_W  number of samples in the region; captured on an accepted start.
- atten  in  3  arithmetic right-shift applied to each sample; live input.
- rom_addr  out  ADDR_W  ROM address.
- rom_q  in  SAMPLE_W  ROM data, valid exactly 1 cycle after rom_addr changes.
- audio_out_allowed  in  1  Audio_Controller FIFO has space.
- write_audio_out  out  1  FIFO write strobe.
- left_channel_audio_out  out  32  sample to FIFO.
- right_channel_audio_out  out  32  same value as left.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when a one-shot region completes.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; rom_addr, sample register, repeat counter and remaining counter all 0; write_audio_out=0, busy=0, done=0; both audio outputs 0.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - start=1 and length!=0: capture start_reg=start_addr, len_reg=length; set cur_addr=start_addr, remaining=length, rep_cnt=0; go to FETCH.
  - start with length=0: ignored; no done pulse.
- FETCH: rom_addr<=cur_addr (registered); go to WAIT.
- WAIT: latch rom_q into sample_reg; go to PLAY. Fetch latency is 2 cycles from FETCH entry to a valid sample.
- PLAY:
  - write_audio_out = audio_out_allowed (combinational AND, high only in PLAY).
  - Each cycle with a write: if rep_cnt < REPEAT-1, increment rep_cnt and stay in PLAY.
  - Otherwise clear rep_cnt, then:
    - remaining>1: cur_addr<=cur_addr+1 (wraps), remaining<=remaining-1, go to FETCH.
    - remaining==1 and loop_mode=1: cur_addr<=start_reg, remaining<=len_reg, go to FETCH; no done pulse.
    - remaining==1 and loop_mode=0: done=1 for the next cycle, go to IDLE.
- No FIFO writes occur in FETCH or WAIT. The FIFO absorbs the gap; at 48 kHz there are about 1042 cycles per sample.
- Audio output data:
  - SAMPLE_W-bit value = sample_reg >>> atten (sign-preserving).
  - Placed in bits [31:32-SAMPLE_W]; low bits are zero.
  - Outputs are 0 when not in PLAY.
- stop=1 in any state: go to IDLE next cycle; write_audio_out is forced 0 that cycle; no done pulse. Stop has priority over start, over a write, and over end-of-region.
- start while busy: ignored; captured region and counters unchanged.
- Mid-play changes to start_addr or length have no effect until the next accepted start. atten and loop_mode act live.
- Address wrap: start_addr=2^ADDR_W-2 with length=4 reads the sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Test Plan:
- Reset mid-PLAY, with write_audio_out high: all outputs 0 immediately (asynchronously); busy=0; after release, no writes until a new start.
- One-shot: ROM[a]=a, start_addr=100, length=3, REPEAT=1, audio_out_allowed=1.
  - Writes carry 100, 101, 102 in upper 16 bits.
  - done pulses once, 1 cycle after the third write; busy then falls.
- Loop plus REPEAT: loop_mode=1, length=2, start_addr=10, REPEAT=3.
  - Write sequence is 10,10,10,11,11,11,10,10,10...
  - done never asserts; stop ends playback within 1 cycle.
- Backpressure: audio_out_allowed low for 50 cycles while in PLAY.
  - No write occurs; the sample is held.
  - Exactly one write occurs on the first allowed cycle, with no sample lost or duplicated.
- Attenuation and sign: rom_q=16'h8000 with atten=1 gives output 32'hC000_0000; rom_q=16'h7FFE with atten=3 gives 32'h0FFF_0000.
- Corner events:
  - start with length=0: stays IDLE, no done.
  - start while busy: ignored.
  - start and stop together in IDLE: stays IDLE.
  - Wrap case 0xFFFE, length 4: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
